dmem_responder: RTL and testbench

- Data-memory responder servicing CPU load/store requests over a valid/ready request/response handshake.
- Sits on the memory side of the core's data port: accepts one access at a time, waits a configurable latency, performs the byte/half/word access, then returns read data or an error.
- Owns a word-organised RAM with per-byte write enables.

---
 rtl/dmem_responder.sv | 210 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with a
// word-organised RAM, byte/half/word access and fixed response latency.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   req_valid/ready     request handshake (req_ready = idle)
//   req_wen             1 = store, 0 = load
//   req_memop           RV32 funct3 width code (B/H/W/BU/HU)
//   req_addr/wdata      byte address, right-aligned store data
//   rsp_valid/ready     response handshake
//   rsp_rdata, rsp_err  extended load data (0 on store/error), fault flag
//
// Optional: define DMEM_MISALIGN_CHK_EN to fault misaligned H/HU/W
// accesses; otherwise low address bits are forced to alignment.

module dmem_responder #(
    parameter int DEPTH = 1024,
    parameter int LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_memop,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

`ifdef DMEM_MISALIGN_CHK_EN
    localparam bit MISALIGN_CHK = 1'b1;
`else
    localparam bit MISALIGN_CHK = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_nxt;
    logic           w_capture;

    logic           r_wen;
    logic [2:0]     r_memop;
    logic [31:0]    r_addr;
    logic [31:0]    r_wdata;

    logic           r_rsp_valid;
    logic           w_rsp_valid_nxt;
    logic [31:0]    r_rsp_rdata;
    logic [31:0]    w_rsp_rdata_nxt;
    logic           r_rsp_err;
    logic           w_rsp_err_nxt;

    logic [31:0]    r_mem [DEPTH];

    logic [AW-1:0]  w_idx;
    logic [31:0]    w_word;
    logic [1:0]     w_off;
    logic [3:0]     w_be;
    logic           w_bad_op;
    logic           w_misal;
    logic           w_oor;
    logic           w_err;
    logic           w_access;
    logic [31:0]    w_sh;
    logic [31:0]    w_wsh;
    logic [31:0]    w_load;

    assign w_idx    = r_addr[AW+1:2];
    assign w_word   = r_mem[w_idx];
    assign w_oor    = |r_addr[31:AW+2];
    assign w_err    = w_bad_op | w_oor | (MISALIGN_CHK & w_misal);
    assign w_access = (r_state == S_WAIT) && (r_cnt == '0);
    assign w_sh     = w_word >> {w_off, 3'b000};
    assign w_wsh    = r_wdata << {w_off, 3'b000};

    // Lane offset/enables; H and W offsets are forced to alignment so
    // that an unchecked misaligned access silently rounds down.
    always_comb begin
        w_off    = 2'b00;
        w_be     = 4'b0000;
        w_bad_op = 1'b0;
        w_misal  = 1'b0;
        case (r_memop)
            3'b000, 3'b100: begin
                w_off = r_addr[1:0];
                w_be  = 4'b0001 << r_addr[1:0];
            end
            3'b001, 3'b101: begin
                w_off   = {r_addr[1], 1'b0};
                w_be    = 4'b0011 << {r_addr[1], 1'b0};
                w_misal = r_addr[0];
            end
            3'b010: begin
                w_be    = 4'b1111;
                w_misal = |r_addr[1:0];
            end
            default: w_bad_op = 1'b1;
        endcase
        if (r_wen && r_memop[2]) begin
            w_bad_op = 1'b1;
        end
    end

    always_comb begin
        w_load = 32'h0;
        case (r_memop)
            3'b000:  w_load = {{24{w_sh[7]}}, w_sh[7:0]};
            3'b001:  w_load = {{16{w_sh[15]}}, w_sh[15:0]};
            3'b010:  w_load = w_sh;
            3'b100:  w_load = {24'h0, w_sh[7:0]};
            3'b101:  w_load = {16'h0, w_sh[15:0]};
            default: w_load = 32'h0;
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_capture       = 1'b0;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = CW'(LAT - 1);
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = w_err;
                    w_rsp_rdata_nxt = (r_wen || w_err) ? 32'h0 : w_load;
                    w_state_nxt     = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_rsp_rdata_nxt = 32'h0;
                    w_rsp_err_nxt   = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_wen       <= 1'b0;
            r_memop     <= 3'b000;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            if (w_capture) begin
                r_wen   <= req_wen;
                r_memop <= req_memop;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
        end
    end

    // RAM is not reset; a reset before the write edge drops the store
    // because the FSM leaves WAIT.
    always_ff @(posedge clk) begin
        if (w_access && r_wen && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wsh[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder (LAT=2,
// DEPTH=1024); expectations queued at issue, compared at response.

module tb_dmem_responder;

    localparam int LAT = 2;

    typedef struct packed {
        logic        wen;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] ed;
        logic        ee;
    } tx_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [2:0]  req_memop;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int  total = 0;
    int  bad   = 0;
    tx_t sb[$];

    dmem_responder #(.DEPTH(1024), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_memop (req_memop),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one request, wait for acceptance, queue its expectation,
    // then scramble the request bus to show it is not re-sampled.
    task automatic send(input tx_t t);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_wen   = t.wen;
        req_memop = t.op;
        req_addr  = t.a;
        req_wdata = t.wd;
        while (!req_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (n >= 50) begin
            bad++;
            $display("FAIL accept_timeout: req_ready=%b want 1", req_ready);
        end
        @(posedge clk);
        #1;
        sb.push_back(t);
        req_valid = 1'b0;
        req_wen   = 1'($urandom);
        req_memop = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic get_rsp(output logic [31:0] d, output logic e,
                           output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        d = rsp_rdata;
        e = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_memop = 3'b000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_req_ready: got %b want 1", req_ready);
        end
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid);
        end
        total++;
        if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_rsp_data: got %h/%b want 0/0",
                     rsp_rdata, rsp_err);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_word;
        tx_t t [2];
        tx_t x;
        logic [31:0] d;
        logic e;
        int cyc;
        t = '{'{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0},
              '{1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0}};
        foreach (t[i]) begin
            send(t[i]);
            get_rsp(d, e, cyc);
            x = sb.pop_front();
            total++;
            if (cyc !== LAT) begin
                bad++;
                $display("FAIL word_lat[%0d]: got %0d want %0d", i, cyc, LAT);
            end
            total++;
            if (d !== x.ed || e !== x.ee) begin
                bad++;
                $display("FAIL word_rsp[%0d]: got %h/%b want %h/%b",
                         i, d, e, x.ed, x.ee);
            end
            total++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                bad++;
                $display("FAIL word_done[%0d]: valid=%b ready=%b want 0/1",
                         i, rsp_valid, req_ready);
            end
        end
    endtask

    task automatic test_bytes;
        tx_t t [10];
        tx_t x;
        logic [31:0] d;
        logic e;
        int cyc;
        t = '{'{1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0},
              '{1'b1, 3'b000, 32'h21, 32'hABCDEF80, 32'h0, 1'b0},
              '{1'b0, 3'b000, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0},
              '{1'b0, 3'b100, 32'h21, 32'h0, 32'h00000080, 1'b0},
              '{1'b0, 3'b010, 32'h20, 32'h0, 32'h11228044, 1'b0},
              '{1'b0, 3'b001, 32'h22, 32'h0, 32'h00001122, 1'b0},
              '{1'b1, 3'b010, 32'h24, 32'h0, 32'h0, 1'b0},
              '{1'b1, 3'b001, 32'h26, 32'h5555BEEF, 32'h0, 1'b0},
              '{1'b0, 3'b001, 32'h26, 32'h0, 32'hFFFFBEEF, 1'b0},
              '{1'b0, 3'b101, 32'h26, 32'h0, 32'h0000BEEF, 1'b0}};
        foreach (t[i]) begin
            send(t[i]);
            get_rsp(d, e, cyc);
            x = sb.pop_front();
            total++;
            if (cyc !== LAT || d !== x.ed || e !== x.ee) begin
                bad++;
                $display("FAIL bytes[%0d]: got lat=%0d %h/%b want lat=%0d %h/%b",
                         i, cyc, d, e, LAT, x.ed, x.ee);
            end
        end
    endtask

    task automatic test_back_to_back;
        tx_t t;
        tx_t x;
        logic [31:0] d;
        logic [31:0] d0;
        logic e;
        int cyc;
        t = '{1'b1, 3'b010, 32'h30, 32'h55AA55AA, 32'h0, 1'b0};
        send(t);
        get_rsp(d, e, cyc);
        x = sb.pop_front();
        t = '{1'b0, 3'b010, 32'h30, 32'h0, 32'h55AA55AA, 1'b0};
        send(t);
        cyc = 0;
        while (!rsp_valid && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        total++;
        if (cyc !== LAT) begin
            bad++;
            $display("FAIL bp_lat: got %0d want %0d", cyc, LAT);
        end
        d0 = rsp_rdata;
        x = sb.pop_front();
        total++;
        if (d0 !== x.ed || rsp_err !== x.ee) begin
            bad++;
            $display("FAIL bp_data: got %h/%b want %h/%b",
                     d0, rsp_err, x.ed, x.ee);
        end
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_memop = 3'b010;
        req_addr  = 32'h10;
        req_wdata = 32'h0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== d0 ||
                rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d]: v=%b d=%h e=%b rdy=%b want 1/%h/0/0",
                         k, rsp_valid, rsp_rdata, rsp_err, req_ready, d0);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: v=%b rdy=%b want 0/1",
                     rsp_valid, req_ready);
        end
        sb.push_back('{1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_accept: rdy=%b want 0", req_ready);
        end
        get_rsp(d, e, cyc);
        x = sb.pop_front();
        total++;
        if (cyc !== LAT || d !== x.ed || e !== x.ee) begin
            bad++;
            $display("FAIL bp_next: got lat=%0d %h/%b want lat=%0d %h/%b",
                     cyc, d, e, LAT, x.ed, x.ee);
        end
    endtask

    task automatic test_errors;
        tx_t t [6];
        tx_t x;
        logic [31:0] d;
        logic e;
        int cyc;
        t = '{'{1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1},
              '{1'b1, 3'b100, 32'h10, 32'h12345678, 32'h0, 1'b1},
              '{1'b1, 3'b101, 32'h10, 32'h12345678, 32'h0, 1'b1},
              '{1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1},
              '{1'b1, 3'b010, 32'h8000_0010, 32'h12345678, 32'h0, 1'b1},
              '{1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0}};
        foreach (t[i]) begin
            send(t[i]);
            get_rsp(d, e, cyc);
            x = sb.pop_front();
            total++;
            if (cyc !== LAT || d !== x.ed || e !== x.ee) begin
                bad++;
                $display("FAIL err[%0d]: got lat=%0d %h/%b want lat=%0d %h/%b",
                         i, cyc, d, e, LAT, x.ed, x.ee);
            end
        end
    endtask

    task automatic test_misalign;
        tx_t t [3];
        tx_t x;
        logic [31:0] d;
        logic e;
        int cyc;
`ifdef DMEM_MISALIGN_CHK_EN
        t = '{'{1'b0, 3'b001, 32'h13, 32'h0, 32'h0, 1'b1},
              '{1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1},
              '{1'b1, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1}};
`else
        t = '{'{1'b0, 3'b001, 32'h13, 32'h0, 32'hFFFFDEAD, 1'b0},
              '{1'b0, 3'b010, 32'h11, 32'h0, 32'hDEADBEEF, 1'b0},
              '{1'b0, 3'b101, 32'h11, 32'h0, 32'h0000BEEF, 1'b0}};
`endif
        foreach (t[i]) begin
            send(t[i]);
            get_rsp(d, e, cyc);
            x = sb.pop_front();
            total++;
            if (cyc !== LAT || d !== x.ed || e !== x.ee) begin
                bad++;
                $display("FAIL misal[%0d]: got lat=%0d %h/%b want lat=%0d %h/%b",
                         i, cyc, d, e, LAT, x.ed, x.ee);
            end
        end
    endtask

    task automatic test_reset_mid;
        tx_t x;
        logic [31:0] d;
        logic e;
        int cyc;
        send('{1'b1, 3'b010, 32'h40, 32'h0, 32'h0, 1'b0});
        get_rsp(d, e, cyc);
        x = sb.pop_front();
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_memop = 3'b010;
        req_addr  = 32'h40;
        req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_accept: rdy=%b want 0", req_ready);
        end
        rst = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 ||
            rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_outs: rdy=%b v=%b d=%h e=%b want 1/0/0/0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_novalid: v=%b want 0", rsp_valid);
        end
        send('{1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1'b0});
        get_rsp(d, e, cyc);
        x = sb.pop_front();
        total++;
        if (cyc !== LAT || d !== x.ed || e !== x.ee) begin
            bad++;
            $display("FAIL rstmid_load: got lat=%0d %h/%b want lat=%0d %h/%b",
                     cyc, d, e, LAT, x.ed, x.ee);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_bytes();
        test_back_to_back();
        test_errors();
        test_misalign();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_empty: got %0d entries want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
